// File: rtl/cmd_parser_pkg.sv
// Shared constants for the parameter command parser: opcodes, reply bytes,
// state encodings and a constant helper for counter sizing.
package cmd_parser_pkg;

    localparam logic [7:0] OP_SET_HASH = 8'h01;
    localparam logic [7:0] OP_PROC     = 8'h02;
    localparam logic [7:0] OP_RET_POS  = 8'h03;

    localparam logic [7:0] ACK_BYTE    = 8'h01;
    localparam logic [7:0] NACK_BYTE   = 8'h00;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_SET_HASH  = 4'd1;
    localparam state_t ST_PROC_LEN  = 4'd2;
    localparam state_t ST_PROC_DATA = 4'd3;
    localparam state_t ST_PROC_WAIT = 4'd4;
    localparam state_t ST_RET_POS   = 4'd5;
    localparam state_t ST_RET_STR   = 4'd6;
    localparam state_t ST_SEND_ACK  = 4'd7;
    localparam state_t ST_SEND_NACK = 4'd8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// Paces bytes into the UART transmitter: one-cycle txd_start with data, only
// when the transmitter is idle and never on two adjacent cycles.
module tx_byte_sender (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       txd_busy,
    output logic       txd_start,
    output logic [7:0] txd_data
);

    // Blocking on our own strobe gives the transmitter a cycle to raise busy.
    assign tx_ready = !txd_busy && !txd_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            txd_start <= 1'b0;
            txd_data  <= '0;
        end else begin
            txd_start <= tx_valid && tx_ready;
            if (tx_valid && tx_ready)
                txd_data <= tx_byte;
        end
    end

endmodule

// File: rtl/param_cmd_parser.sv
// Byte-serial command parser: loads the target hash, streams data to the
// search engine, and returns the match position and string.
module param_cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int HASH_BYTES  = 16,
    parameter int CNT_BYTES   = 2,
    parameter int POS_BYTES   = 2,
    parameter int MATCH_LEN   = 19,
    parameter int TIMEOUT_CYC = 12000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rxd_data,
    input  logic                    rxd_data_ready,
    input  logic                    txd_busy,
    output logic                    txd_start,
    output logic [7:0]              txd_data,
    input  logic                    proc_done,
    input  logic                    proc_match,
    input  logic [8*POS_BYTES-1:0]  proc_byte_pos,
    input  logic [7:0]              proc_match_char,
    output logic                    proc_start,
    output logic [8*CNT_BYTES-1:0]  proc_num_bytes,
    output logic [7:0]              proc_data,
    output logic                    proc_data_valid,
    output logic                    proc_match_char_next,
    output logic [8*HASH_BYTES-1:0] proc_target_hash,
    output logic [3:0]              state_dbg
);

    localparam int CNT_W  = 8 * CNT_BYTES;
    localparam int POS_W  = 8 * POS_BYTES;
    localparam int HASH_W = 8 * HASH_BYTES;
    localparam int CW     = $clog2(max3(HASH_BYTES, MATCH_LEN, 2**CNT_W)) + 1;
    localparam int GW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t            state;
    logic [CW-1:0]     cnt, cnt_inc;
    logic [HASH_W-1:0] hash_shadow, hash_shift;
    logic [CNT_W-1:0]  num_shift;
    logic [POS_W-1:0]  pos_reg;
    logic [GW-1:0]     gap, gap_inc;
    logic              timer_active, timeout;
    logic [7:0]        tx_byte;
    logic              tx_valid, tx_ready, tx_fire;

    assign cnt_inc    = cnt + CW'(1);
    assign gap_inc    = gap + GW'(1);
    assign hash_shift = (hash_shadow << 8) | HASH_W'(rxd_data);
    assign num_shift  = (proc_num_bytes << 8) | CNT_W'(rxd_data);
    assign state_dbg  = state;

    assign timer_active = (state == ST_SET_HASH) || (state == ST_PROC_LEN) ||
                          (state == ST_PROC_DATA);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = (TIMEOUT_CYC != 0) && timer_active && !rxd_data_ready &&
                     (gap_inc == GW'(TIMEOUT_CYC));

    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = NACK_BYTE;
        case (state)
            ST_RET_POS:   begin tx_valid = 1'b1; tx_byte = pos_reg[POS_W-1 -: 8]; end
            ST_RET_STR:   begin tx_valid = 1'b1; tx_byte = proc_match_char;       end
            ST_SEND_ACK:  begin tx_valid = 1'b1; tx_byte = ACK_BYTE;              end
            ST_SEND_NACK: begin tx_valid = 1'b1; tx_byte = NACK_BYTE;             end
            default:      ;
        endcase
    end

    assign tx_fire = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            gap                  <= '0;
            hash_shadow          <= '0;
            pos_reg              <= '0;
            proc_target_hash     <= '0;
            proc_num_bytes       <= '0;
            proc_data            <= '0;
            proc_start           <= 1'b0;
            proc_data_valid      <= 1'b0;
            proc_match_char_next <= 1'b0;
        end else begin
            proc_start           <= 1'b0;
            proc_data_valid      <= 1'b0;
            proc_match_char_next <= 1'b0;
            gap <= (timer_active && !rxd_data_ready) ? gap_inc : '0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rxd_data_ready) begin
                        case (rxd_data)
                            OP_SET_HASH: begin
                                hash_shadow <= '0;
                                state       <= ST_SET_HASH;
                            end
                            OP_PROC: begin
                                proc_num_bytes <= '0;
                                state          <= ST_PROC_LEN;
                            end
                            OP_RET_POS: begin
                                pos_reg <= proc_byte_pos;
                                state   <= ST_RET_POS;
                            end
                            default: state <= ST_SEND_NACK;
                        endcase
                    end
                end

                ST_SET_HASH: begin
                    if (rxd_data_ready) begin
                        hash_shadow <= hash_shift;
                        cnt         <= cnt_inc;
                        if (cnt_inc == CW'(HASH_BYTES)) begin
                            proc_target_hash <= hash_shift;
                            cnt              <= '0;
                            state            <= ST_SEND_ACK;
                        end
                    end else if (timeout) begin
                        hash_shadow <= '0;
                        cnt         <= '0;
                        state       <= ST_SEND_NACK;
                    end
                end

                ST_PROC_LEN: begin
                    if (rxd_data_ready) begin
                        proc_num_bytes <= num_shift;
                        cnt            <= cnt_inc;
                        if (cnt_inc == CW'(CNT_BYTES)) begin
                            cnt <= '0;
                            if (num_shift == '0) begin
                                state <= ST_SEND_NACK;
                            end else begin
                                proc_start <= 1'b1;
                                state      <= ST_PROC_DATA;
                            end
                        end
                    end else if (timeout) begin
                        cnt   <= '0;
                        state <= ST_SEND_NACK;
                    end
                end

                ST_PROC_DATA: begin
                    if (rxd_data_ready) begin
                        proc_data       <= rxd_data;
                        proc_data_valid <= 1'b1;
                        cnt             <= cnt_inc;
                        if (cnt_inc == CW'(proc_num_bytes)) begin
                            cnt   <= '0;
                            state <= ST_PROC_WAIT;
                        end
                    end else if (timeout) begin
                        cnt   <= '0;
                        state <= ST_SEND_NACK;
                    end
                end

                ST_PROC_WAIT: begin
                    if (proc_done)
                        state <= proc_match ? ST_SEND_ACK : ST_SEND_NACK;
                end

                ST_RET_POS: begin
                    if (tx_fire) begin
                        pos_reg <= pos_reg << 8;
                        cnt     <= cnt_inc;
                        if (cnt_inc == CW'(POS_BYTES)) begin
                            cnt   <= '0;
                            state <= ST_RET_STR;
                        end
                    end
                end

                ST_RET_STR: begin
                    if (tx_fire) begin
                        proc_match_char_next <= 1'b1;
                        cnt                  <= cnt_inc;
                        if (cnt_inc == CW'(MATCH_LEN)) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_SEND_ACK, ST_SEND_NACK: begin
                    if (tx_fire)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    tx_byte_sender u_tx (
        .clk       (clk),
        .reset     (reset),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .txd_busy  (txd_busy),
        .txd_start (txd_start),
        .txd_data  (txd_data)
    );

endmodule

// File: tb/tb_param_cmd_parser.sv
// Bench for param_cmd_parser: a protocol-level model predicts replies, engine
// pulses and hash contents; a monitor compares the DUT against it each cycle.
module tb_param_cmd_parser;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rxd_data;
    logic         rxd_data_ready;
    logic         txd_busy;
    logic         txd_start;
    logic [7:0]   txd_data;
    logic         proc_done;
    logic         proc_match;
    logic [15:0]  proc_byte_pos;
    logic [7:0]   proc_match_char;
    logic         proc_start;
    logic [15:0]  proc_num_bytes;
    logic [7:0]   proc_data;
    logic         proc_data_valid;
    logic         proc_match_char_next;
    logic [127:0] proc_target_hash;
    logic [3:0]   state_dbg;

    param_cmd_parser #(
        .HASH_BYTES  (16),
        .CNT_BYTES   (2),
        .POS_BYTES   (2),
        .MATCH_LEN   (19),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .rxd_data             (rxd_data),
        .rxd_data_ready       (rxd_data_ready),
        .txd_busy             (txd_busy),
        .txd_start            (txd_start),
        .txd_data             (txd_data),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .proc_start           (proc_start),
        .proc_num_bytes       (proc_num_bytes),
        .proc_data            (proc_data),
        .proc_data_valid      (proc_data_valid),
        .proc_match_char_next (proc_match_char_next),
        .proc_target_hash     (proc_target_hash),
        .state_dbg            (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: busy for busy_len cycles after each start.
    int busy_len = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (txd_start === 1'b1) busy_cnt <= busy_len;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end
    assign txd_busy = (busy_cnt != 0);

    // Engine stand-in: match string is 'A','B',... advanced by each next pulse.
    int char_k = 0;
    always @(posedge clk) if (proc_match_char_next === 1'b1) char_k <= char_k + 1;
    assign proc_match_char = 8'h41 + 8'(char_k);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- protocol-level model ----------------
    logic [7:0]   exp_tx[$];
    logic [7:0]   exp_dv[$];
    int           exp_start[$];
    int           mode = 0;   // 0 idle, 1 hash, 2 length, 3 data, 4 awaiting engine
    int           need = 0;
    int           len_acc = 0;
    logic [127:0] acc = '0;
    logic [127:0] model_hash = '0;
    int           model_next_total = 0;

    task automatic model_byte(input logic [7:0] b);
        case (mode)
            0: begin
                if (b == 8'h01) begin
                    mode = 1; need = 16; acc = '0;
                end else if (b == 8'h02) begin
                    mode = 2; need = 2; len_acc = 0;
                end else if (b == 8'h03) begin
                    exp_tx.push_back(proc_byte_pos[15:8]);
                    exp_tx.push_back(proc_byte_pos[7:0]);
                    for (int i = 0; i < 19; i++)
                        exp_tx.push_back(8'h41 + 8'(model_next_total + i));
                    model_next_total += 19;
                end else begin
                    exp_tx.push_back(8'h00);
                end
            end
            1: begin
                acc = {acc[119:0], b};
                need--;
                if (need == 0) begin
                    model_hash = acc;
                    exp_tx.push_back(8'h01);
                    mode = 0;
                end
            end
            2: begin
                len_acc = len_acc * 256 + int'(b);
                need--;
                if (need == 0) begin
                    if (len_acc == 0) begin
                        exp_tx.push_back(8'h00);
                        mode = 0;
                    end else begin
                        exp_start.push_back(len_acc);
                        need = len_acc;
                        mode = 3;
                    end
                end
            end
            3: begin
                exp_dv.push_back(b);
                need--;
                if (need == 0) mode = 4;
            end
            default: ;
        endcase
    endtask

    task automatic model_done(input logic m);
        if (mode == 4) begin
            exp_tx.push_back(m ? 8'h01 : 8'h00);
            mode = 0;
        end
    endtask

    task automatic model_timeout();
        mode = 0;
        exp_tx.push_back(8'h00);
    endtask

    task automatic model_reset();
        mode = 0;
        exp_tx.delete();
        exp_dv.delete();
        exp_start.delete();
        model_hash = '0;
    endtask

    // ---------------- monitor ----------------
    int   n_tx = 0, n_next = 0, n_dv = 0, n_start = 0;
    int   last_start = -100;
    int   last_rx = 0;
    int   cur_len = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (txd_start === 1'b1) begin
            n_tx++;
            check("tx_expected", 128'(exp_tx.size() != 0), 128'd1);
            if (exp_tx.size() != 0) check("txd_data", 128'(txd_data), 128'(exp_tx.pop_front()));
            check("tx_gap", 128'((cyc - last_start) >= 2), 128'd1);
            check("tx_busy_idle", 128'(busy_prev), 128'd0);
            last_start = cyc;
        end
        if (proc_match_char_next === 1'b1) begin
            n_next++;
            check("next_with_start", 128'(txd_start), 128'd1);
        end
        if (proc_data_valid === 1'b1) begin
            n_dv++;
            check("dv_expected", 128'(exp_dv.size() != 0), 128'd1);
            if (exp_dv.size() != 0) check("proc_data", 128'(proc_data), 128'(exp_dv.pop_front()));
            check("len_stable", 128'(proc_num_bytes), 128'(cur_len));
        end
        if (proc_start === 1'b1) begin
            n_start++;
            check("start_expected", 128'(exp_start.size() != 0), 128'd1);
            if (exp_start.size() != 0) begin
                cur_len = exp_start.pop_front();
                check("proc_num_bytes", 128'(proc_num_bytes), 128'(cur_len));
            end
        end
        busy_prev = txd_busy;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rxd_data = b;
        rxd_data_ready = 1'b1;
        last_rx = cyc;
        model_byte(b);
        @(posedge clk); #1;
        rxd_data_ready = 1'b0;
        rxd_data = 8'h00;
    endtask

    task automatic engine_done(input logic m);
        @(posedge clk); #1;
        proc_match = m;
        proc_done = 1'b1;
        model_done(m);
        @(posedge clk); #1;
        proc_done = 1'b0;
    endtask

    task automatic settle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_tx.size() == 0 && exp_dv.size() == 0 && exp_start.size() == 0) break;
            @(posedge clk);
        end
        repeat (6) @(posedge clk);
        #1;
        check("drain_tx", 128'(exp_tx.size()), 128'd0);
        check("drain_dv", 128'(exp_dv.size()), 128'd0);
        check("drain_start", 128'(exp_start.size()), 128'd0);
        check("hash_model", proc_target_hash, model_hash);
    endtask

    localparam logic [127:0] HASH_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        int t_tx, t_dv, t_st, t_nx, lat;
        rxd_data = 8'h00; rxd_data_ready = 1'b0;
        proc_done = 1'b0; proc_match = 1'b0; proc_byte_pos = 16'h0000;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_txd_start", 128'(txd_start), 128'd0);
        check("rst_txd_data", 128'(txd_data), 128'd0);
        check("rst_proc_start", 128'(proc_start), 128'd0);
        check("rst_num_bytes", 128'(proc_num_bytes), 128'd0);
        check("rst_proc_data", 128'(proc_data), 128'd0);
        check("rst_dv", 128'(proc_data_valid), 128'd0);
        check("rst_next", 128'(proc_match_char_next), 128'd0);
        check("rst_hash", proc_target_hash, 128'd0);
        check("rst_state", 128'(state_dbg), 128'd0);

        // Load hash 00..0F
        t_tx = n_tx;
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        settle(200);
        check("s1_hash_literal", proc_target_hash, HASH_SEQ);
        check("s1_tx_count", 128'(n_tx - t_tx), 128'd1);
        check("s1_ack_literal", 128'(txd_data), 128'h01);

        // Process "abc", long engine wait, match
        t_tx = n_tx; t_dv = n_dv; t_st = n_start;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        repeat (60) @(posedge clk);
        #1;
        check("s2_num_bytes", 128'(proc_num_bytes), 128'd3);
        check("s2_start_count", 128'(n_start - t_st), 128'd1);
        check("s2_dv_count", 128'(n_dv - t_dv), 128'd3);
        engine_done(1'b1);
        settle(200);
        check("s2_tx_count", 128'(n_tx - t_tx), 128'd1);
        check("s2_ack_literal", 128'(txd_data), 128'h01);

        // Zero length
        t_tx = n_tx; t_st = n_start;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        settle(200);
        check("s3_start_count", 128'(n_start - t_st), 128'd0);
        check("s3_tx_count", 128'(n_tx - t_tx), 128'd1);
        check("s3_nack_literal", 128'(txd_data), 128'h00);

        // Return position and string with a slow transmitter
        busy_len = 10;
        proc_byte_pos = 16'h1234;
        t_tx = n_tx; t_nx = n_next;
        send_byte(8'h03);
        settle(800);
        check("s4_tx_count", 128'(n_tx - t_tx), 128'd21);
        check("s4_next_count", 128'(n_next - t_nx), 128'd19);
        check("s4_next_model", 128'(n_next), 128'(model_next_total));
        busy_len = 0;

        // Timeout mid hash load
        t_tx = n_tx;
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        model_timeout();
        settle(200);
        lat = last_start - last_rx;
        check("s5_timeout_latency", 128'(lat >= 50 && lat <= 52), 128'd1);
        check("s5_hash_kept", proc_target_hash, HASH_SEQ);
        check("s5_tx_count", 128'(n_tx - t_tx), 128'd1);
        check("s5_nack_literal", 128'(txd_data), 128'h00);

        // Unknown opcode
        t_tx = n_tx;
        send_byte(8'h7F);
        settle(200);
        check("s6_tx_count", 128'(n_tx - t_tx), 128'd1);
        check("s6_nack_literal", 128'(txd_data), 128'h00);

        // No match; a byte during the engine wait is ignored
        t_tx = n_tx; t_dv = n_dv;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h78); send_byte(8'h79);
        repeat (5) @(posedge clk);
        send_byte(8'h01);
        repeat (5) @(posedge clk);
        engine_done(1'b0);
        settle(200);
        check("s7_tx_count", 128'(n_tx - t_tx), 128'd1);
        check("s7_dv_count", 128'(n_dv - t_dv), 128'd2);
        check("s7_nack_literal", 128'(txd_data), 128'h00);

        // Reset in the middle of the data phase
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h10); send_byte(8'h11);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        t_dv = n_dv; t_tx = n_tx;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("s8_state_idle", 128'(state_dbg), 128'd0);
        check("s8_hash_cleared", proc_target_hash, 128'd0);
        check("s8_num_cleared", 128'(proc_num_bytes), 128'd0);
        repeat (30) @(posedge clk);
        #1;
        check("s8_no_dv", 128'(n_dv - t_dv), 128'd0);
        check("s8_no_tx", 128'(n_tx - t_tx), 128'd0);
        send_byte(8'h7F);
        settle(200);
        check("s8_alive_tx", 128'(n_tx - t_tx), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
